// File: rtl/clk_div_phy_pkg.sv
// Shared PHY constants for the clock divider, serializer and deserializer blocks.
// Holds divider/wrap-counter widths and the terminal divider count.
package clk_div_phy_pkg;

  localparam int DIV_W  = 3;
  localparam int LOCK_W = 4;

  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'((1 << DIV_W) - 1);

endpackage

// File: rtl/clk_div_phy.sv
// Divide-by-2/4/8 clock generator with period strobe and lock flag; outputs are flop-direct, 1-cycle latency.
// No backpressure: enable=0 freezes all state and suppresses the strobe.
module clk_div_phy
  import clk_div_phy_pkg::*;
#(
  parameter int LOCK_PERIODS = 1
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             enable,
  output logic             clk_out_4f,
  output logic             clk_out_2f,
  output logic             clk_out_f,
  output logic             stb_f,
  output logic [DIV_W-1:0] phase,
  output logic             locked
);

  localparam logic [LOCK_W-1:0] LOCK_TGT = LOCK_W'(LOCK_PERIODS);

  logic [DIV_W-1:0]  cnt;
  logic [LOCK_W-1:0] wrap_cnt;
  logic [LOCK_W-1:0] wrap_cnt_nxt;
  logic              stb_q;
  logic              locked_q;
  logic              wrap;

  assign wrap = enable && (cnt == DIV_MAX);

  always_comb begin
    wrap_cnt_nxt = wrap_cnt;
    if (wrap && (wrap_cnt != LOCK_TGT)) begin
      wrap_cnt_nxt = wrap_cnt + 1'b1;
    end
  end

  // The strobe is registered from the wrap condition, so a reset-induced zero never pulses it.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      cnt      <= '0;
      wrap_cnt <= '0;
      stb_q    <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      stb_q <= wrap;
      if (enable) begin
        cnt      <= cnt + 1'b1;
        wrap_cnt <= wrap_cnt_nxt;
        locked_q <= locked_q | (wrap_cnt_nxt == LOCK_TGT);
      end
    end
  end

  assign clk_out_4f = cnt[0];
  assign clk_out_2f = cnt[1];
  assign clk_out_f  = cnt[2];
  assign phase      = cnt;
  assign stb_f      = stb_q;
  assign locked     = locked_q;

endmodule

// File: tb/tb_clk_div_phy.sv
// Randomized scoreboard bench for clk_div_phy against a cycle-count reference model.
module tb_clk_div_phy;

  localparam int LOCK_PERIODS = 2;

  logic       clk_in;
  logic       reset;
  logic       enable;
  logic       clk_out_4f;
  logic       clk_out_2f;
  logic       clk_out_f;
  logic       stb_f;
  logic [2:0] phase;
  logic       locked;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Expected output word: {clk_out_f, clk_out_2f, clk_out_4f, stb_f, locked, phase[2:0]}
  logic [7:0] expq[$];

  // Model state: enabled, non-reset cycles since the last reset.
  int n = 0;

  clk_div_phy #(.LOCK_PERIODS(LOCK_PERIODS)) dut (
    .clk_in    (clk_in),
    .reset     (reset),
    .enable    (enable),
    .clk_out_4f(clk_out_4f),
    .clk_out_2f(clk_out_2f),
    .clk_out_f (clk_out_f),
    .stb_f     (stb_f),
    .phase     (phase),
    .locked    (locked)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic step(input bit r, input bit e);
    logic [7:0] exp;
    bit         stb;
    @(negedge clk_in);
    reset  = r;
    enable = e;
    @(posedge clk_in);
    stb = 1'b0;
    if (r) begin
      n = 0;
    end else if (e) begin
      n = n + 1;
      stb = ((n % 8) == 0);
    end
    exp      = '0;
    exp[2:0] = 3'(n % 8);
    exp[3]   = ((n / 8) >= LOCK_PERIODS);
    exp[4]   = stb;
    exp[5]   = ((n % 2) == 1);
    exp[6]   = ((n % 4) >= 2);
    exp[7]   = ((n % 8) >= 4);
    expq.push_back(exp);
  endtask

  initial begin : monitor
    logic [7:0] act;
    logic [7:0] exp;
    forever begin
      @(posedge clk_in);
      #1;
      cyc = cyc + 1;
      if (expq.size() > 0) begin
        exp = expq.pop_front();
        act = {clk_out_f, clk_out_2f, clk_out_4f, stb_f, locked, phase};
        checks = checks + 1;
        if (act !== exp) begin
          errors = errors + 1;
          $display("FAIL outputs cycle %0d: got f/2f/4f/stb/lock/phase=%b required %b", cyc, act, exp);
        end
        if (stb_f === 1'b1) begin
          checks = checks + 1;
          if (phase !== 3'd0) begin
            errors = errors + 1;
            $display("FAIL stb_phase cycle %0d: phase=%0d required 0", cyc, phase);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: stimulus did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    bit r;
    bit e;
    reset  = 1'b1;
    enable = 1'b0;

    // Two reset cycles, then a free run long enough to see lock at 16 and hold.
    repeat (2) step(1'b1, 1'b0);
    repeat (48) step(1'b0, 1'b1);

    // Pause at phase 3, then resume.
    while ((n % 8) != 3) step(1'b0, 1'b1);
    repeat (5) step(1'b0, 1'b0);
    repeat (6) step(1'b0, 1'b1);

    // Reset mid-period while locked.
    while (!(((n % 8) == 6) && ((n / 8) >= LOCK_PERIODS))) step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    repeat (12) step(1'b0, 1'b1);

    // Reset overrides enable.
    repeat (3) step(1'b1, 1'b1);

    // Long continuous run.
    repeat (200) step(1'b0, 1'b1);

    // Random enable with occasional resets.
    repeat (300) begin
      r = ($urandom_range(0, 39) == 0);
      e = ($urandom_range(0, 3) != 0);
      step(r, e);
    end

    repeat (3) @(posedge clk_in);
    #2;
    checks = checks + 1;
    if (expq.size() != 0) begin
      errors = errors + 1;
      $display("FAIL drain: %0d expectations left, required 0", expq.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/clk_div_phy.md
CLK_DIV_PHY -- requirements
Module: clk_div_phy

Interface
REQ-001 Parameter: LOCK_PERIODS, default 1, number of complete clk_out_f periods after reset/enable before locked asserts (legal range 1..15).
REQ-002 Port: clk_in  input  1  single clock of the block; all state updates on its rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset, sampled on rising clk_in.
REQ-004 Port: enable  input  1  1 = divider runs; 0 = all state frozen.
REQ-005 Port: clk_out_4f  output  1  clk_in/2, 50% duty, registered.
REQ-006 Port: clk_out_2f  output  1  clk_in/4, 50% duty, registered.
REQ-007 Port: clk_out_f  output  1  clk_in/8, 50% duty, registered.
REQ-008 Port: stb_f  output  1  one-clk_in-cycle pulse marking the start of each clk_out_f period.
REQ-009 Port: phase  output  3  current divider count; 0..7.
REQ-010 Port: locked  output  1  high once LOCK_PERIODS full clk_out_f periods have elapsed since reset.

Function
REQ-011 The block SHALL hold a 3-bit counter cnt; on each rising clk_in with reset=0 and enable=1, cnt <= cnt+1 modulo 8 (7 wraps to 0).
REQ-012 clk_out_4f, clk_out_2f and clk_out_f SHALL equal cnt[0], cnt[1] and cnt[2] respectively, driven directly from flops with no combinational logic after the register.
REQ-013 phase SHALL equal cnt.
REQ-014 clk_out_f SHALL rise in the cycle cnt becomes 4 and fall in the cycle cnt becomes 0; all three clocks SHALL be 0 together whenever cnt = 0.
REQ-015 stb_f SHALL be registered and equal 1 exactly in the cycles where cnt = 0 as a result of a 7->0 wrap; it SHALL be 0 in the cycle cnt = 0 that results from reset.
REQ-016 A 4-bit saturating wrap counter SHALL increment on every 7->0 wrap and stop at LOCK_PERIODS.
REQ-017 locked SHALL go to 1 in the same cycle the wrap counter reaches LOCK_PERIODS, coinciding with that stb_f pulse, and stay 1 until reset.
REQ-018 With enable=0, cnt, all clock outputs, the wrap counter and locked SHALL hold their values, and stb_f SHALL be 0.
REQ-019 When enable returns to 1, counting SHALL resume from the held cnt with no skipped or repeated value.
REQ-020 Latency: the first edge on clk_out_4f SHALL occur one clk_in cycle after the first cycle in which reset=0 and enable=1.
REQ-021 No output SHALL glitch; each changes at most once per clk_in cycle.

Reset
REQ-022 With reset=1 at a rising clk_in, on the next cycle: cnt=0, clk_out_4f=0, clk_out_2f=0, clk_out_f=0, phase=0, stb_f=0, locked=0, wrap counter=0.
REQ-023 reset SHALL override enable.
REQ-024 A reset asserted mid-period SHALL truncate the current period, with no partial stb_f.
REQ-025 Until the first reset, output values are undefined; the bench SHALL apply reset before checking.

Structure
REQ-026 Constants DIV_W=3 (counter width) and LOCK_W=4 (wrap counter width) SHALL reside in the shared PHY package used by the serializer and deserializer blocks.
REQ-027 The block SHALL be a single module; no sub-module is warranted.

Verification
REQ-028 Reset for 2 cycles, then enable=1 for 16 cycles -> phase sequence 0,1,..,7,0,..7; clk_out_4f toggles every cycle; clk_out_2f every 2 cycles; clk_out_f every 4 cycles.
REQ-029 LOCK_PERIODS=2 with enable=1 from reset -> stb_f high at cycles 8 and 16 after release; locked rises at cycle 16 and stays high for 32 further cycles.
REQ-030 enable=0 for 5 cycles at phase=3 -> all outputs constant, phase stays 3, stb_f=0; after re-enable, phase goes 4,5,...
REQ-031 reset=1 at phase=6 with locked=1 -> next cycle all outputs 0 and locked=0; no stb_f until the following 7->0 wrap.
REQ-032 reset=1 and enable=1 together for 3 cycles -> phase stays 0 and all outputs stay 0.
REQ-033 Continuous self-check over 200 cycles -> clk_out_f period 8 clk_in cycles, high 4; exactly one stb_f per period; stb_f coincides with phase=0.
